video_timing_gen: RTL and testbench

Transmit-side counterpart of the video format detector. Generates progressive raster timing (hsync, vsync, data enable, pixel coordinates) from an 8-bit resolution code, using the same code space as the detector (8'h16 = 1920x1080P60). It sits in front of the video output path, clocked by the pixel-rate i_local_clk. Mode changes apply only on frame boundaries, so the downstream detector never sees a torn frame.

---
 rtl/video_timing_pkg.sv | 83 ++++++++
 rtl/video_timing_if.sv | 31 +++
 rtl/video_timing_counter.sv | 46 ++++
 rtl/video_timing_gen.sv | 139 +++++++++++++
 tb/tb_video_timing_gen.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared types, mode codes and the resolution lookup
// for the video timing generator.
package video_timing_pkg;

  localparam logic [7:0] RES_NONE    = 8'h00;
  localparam logic [7:0] RES_480P60  = 8'h02;
  localparam logic [7:0] RES_720P60  = 8'h04;
  localparam logic [7:0] RES_1080P60 = 8'h16;

  localparam int CW = 13;

  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    cnt_t hact;
    cnt_t hfp;
    cnt_t hsw;
    cnt_t hbp;
    cnt_t vact;
    cnt_t vfp;
    cnt_t vsw;
    cnt_t vbp;
    logic pos;
  } vtiming_t;

  typedef struct packed {
    logic     ok;
    vtiming_t t;
  } vlut_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } vstate_t;

  // Idle mode: empty raster, treated as active-high sync
  localparam vtiming_t T_NONE = '{
    13'd0, 13'd0, 13'd0, 13'd0,
    13'd0, 13'd0, 13'd0, 13'd0,
    1'b1
  };

  function automatic vlut_t vt_lookup(
    input logic [7:0] code
  );
    vlut_t r;
    r.ok = 1'b1;
    r.t  = T_NONE;
    case (code)
      RES_1080P60: r.t = '{
        13'd1920, 13'd88, 13'd44, 13'd148,
        13'd1080, 13'd4, 13'd5, 13'd36,
        1'b1
      };
      RES_720P60: r.t = '{
        13'd1280, 13'd110, 13'd40, 13'd220,
        13'd720, 13'd5, 13'd5, 13'd20,
        1'b1
      };
      RES_480P60: r.t = '{
        13'd720, 13'd16, 13'd62, 13'd60,
        13'd480, 13'd9, 13'd6, 13'd30,
        1'b0
      };
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

  function automatic cnt_t vt_htotal(
    input vtiming_t t
  );
    return t.hact + t.hfp + t.hsw + t.hbp;
  endfunction

  function automatic cnt_t vt_vtotal(
    input vtiming_t t
  );
    return t.vact + t.vfp + t.vsw + t.vbp;
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster output bundle of the timing generator:
// syncs, data enable, coordinates and frame marker.
interface video_timing_if;
  import video_timing_pkg::*;

  logic o_hsync;
  logic o_vsync;
  logic o_de;
  cnt_t o_h_cnt;
  cnt_t o_v_cnt;
  logic o_frame_start;

  modport master (
    output o_hsync,
    output o_vsync,
    output o_de,
    output o_h_cnt,
    output o_v_cnt,
    output o_frame_start
  );

  modport slave (
    input o_hsync,
    input o_vsync,
    input o_de,
    input o_h_cnt,
    input o_v_cnt,
    input o_frame_start
  );

endinterface

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster position counter with
// a combinational last-pixel-of-frame flag.
module video_timing_counter
  import video_timing_pkg::*;
(
  input  logic i_local_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  cnt_t i_htotal,
  input  cnt_t i_vtotal,
  output cnt_t o_h,
  output cnt_t o_v,
  output logic o_frame_end
);

  cnt_t r_h;
  cnt_t r_v;
  logic w_line_end;
  logic w_last_line;

  assign w_line_end  = (r_h == i_htotal - 13'd1);
  assign w_last_line = (r_v == i_vtotal - 13'd1);
  assign o_frame_end = w_line_end && w_last_line;
  assign o_h = r_h;
  assign o_v = r_v;

  // h wraps every line, v advances on h wrap and wraps per frame
  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_clr) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_en) begin
      if (w_line_end) begin
        r_h <= '0;
        r_v <= w_last_line ? '0 : r_v + 13'd1;
      end else begin
        r_h <= r_h + 13'd1;
      end
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Progressive raster timing generator; mode changes
// and stops take effect only at frame boundaries.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter logic [7:0] DEFAULT_CODE      = 8'h00,
  parameter bit         SYNC_ACT_HIGH_OVR = 1'b0
) (
  input  logic           i_local_clk,
  input  logic           i_rst_n,
  input  logic           i_enable,
  input  logic [7:0]     i_resolution,
  video_timing_if.master vid,
  output logic [7:0]     o_cur_resolution,
  output logic           o_timing_valid
);

  vstate_t    r_state;
  vstate_t    w_state_nx;
  logic [7:0] r_req;
  logic [7:0] w_req_nx;
  logic [7:0] r_cur;
  vtiming_t   r_mode;
  logic [7:0] w_code;
  vlut_t      w_lut;
  cnt_t       w_h;
  cnt_t       w_v;
  logic       w_frame_end;
  logic       w_run;
  cnt_t       w_hs_beg;
  cnt_t       w_hs_end;
  cnt_t       w_vs_beg;
  cnt_t       w_vs_end;
  logic       w_de;
  logic       w_hs;
  logic       w_vs;
  logic       w_pos;

  // LOAD reads the latched request, elsewhere the live input
  assign w_code = (r_state == ST_LOAD) ? r_req : i_resolution;
  assign w_lut  = vt_lookup(w_code);
  assign w_run  = (r_state == ST_RUN);

  video_timing_counter u_cnt (
    .i_local_clk (i_local_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (!w_run),
    .i_en        (w_run),
    .i_htotal    (vt_htotal(r_mode)),
    .i_vtotal    (vt_vtotal(r_mode)),
    .o_h         (w_h),
    .o_v         (w_v),
    .o_frame_end (w_frame_end)
  );

  // Next state: inputs sampled only in IDLE and at frame end
  always_comb begin
    w_state_nx = r_state;
    w_req_nx   = r_req;
    unique case (r_state)
      ST_IDLE: begin
        if (i_enable && w_lut.ok) begin
          w_state_nx = ST_LOAD;
          w_req_nx   = i_resolution;
        end
      end
      ST_LOAD: w_state_nx = ST_RUN;
      ST_RUN: begin
        if (w_frame_end) begin
          if (!i_enable || !w_lut.ok) begin
            w_state_nx = ST_IDLE;
          end else if (i_resolution != r_cur) begin
            w_state_nx = ST_LOAD;
            w_req_nx   = i_resolution;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // State, pending request and the active mode table
  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= DEFAULT_CODE;
      r_cur   <= RES_NONE;
      r_mode  <= T_NONE;
    end else begin
      r_state <= w_state_nx;
      r_req   <= w_req_nx;
      if (r_state == ST_LOAD) begin
        r_mode <= w_lut.t;
        r_cur  <= r_req;
      end else if (w_run && w_state_nx == ST_IDLE) begin
        r_mode <= T_NONE;
        r_cur  <= RES_NONE;
      end
    end
  end

  assign w_hs_beg = r_mode.hact + r_mode.hfp;
  assign w_hs_end = w_hs_beg + r_mode.hsw;
  assign w_vs_beg = r_mode.vact + r_mode.vfp;
  assign w_vs_end = w_vs_beg + r_mode.vsw;
  assign w_pos    = SYNC_ACT_HIGH_OVR || r_mode.pos;

  assign w_de = w_run && (w_h < r_mode.hact)
             && (w_v < r_mode.vact);
  assign w_hs = w_run && (w_h >= w_hs_beg)
             && (w_h < w_hs_end);
  assign w_vs = w_run && (w_v >= w_vs_beg)
             && (w_v < w_vs_end);

  // Registered raster outputs, one cycle behind the counters
  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vid.o_hsync       <= 1'b0;
      vid.o_vsync       <= 1'b0;
      vid.o_de          <= 1'b0;
      vid.o_h_cnt       <= '0;
      vid.o_v_cnt       <= '0;
      vid.o_frame_start <= 1'b0;
      o_timing_valid    <= 1'b0;
    end else begin
      vid.o_hsync       <= w_pos ? w_hs : !w_hs;
      vid.o_vsync       <= w_pos ? w_vs : !w_vs;
      vid.o_de          <= w_de;
      vid.o_h_cnt       <= w_h;
      vid.o_v_cnt       <= w_v;
      vid.o_frame_start <= w_run && (w_h == '0)
                        && (w_v == '0);
      o_timing_valid    <= w_run;
    end
  end

  assign o_cur_resolution = r_cur;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: expected raster snapshots are queued
// by the stimulus and compared by a cycle monitor.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] res = 8'h00;
  logic [7:0] cur;
  logic       tv;

  video_timing_if vif ();

  video_timing_gen #(
    .DEFAULT_CODE      (8'h00),
    .SYNC_ACT_HIGH_OVR (1'b0)
  ) dut (
    .i_local_clk      (clk),
    .i_rst_n          (rst_n),
    .i_enable         (en),
    .i_resolution     (res),
    .vid              (vif.master),
    .o_cur_resolution (cur),
    .o_timing_valid   (tv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0]  cur;
    logic        tv;
    logic        fs;
    logic        de;
    logic        hs;
    logic        vs;
    logic [12:0] h;
    logic [12:0] v;
  } obs_t;

  typedef struct {
    int    at;
    string nm;
    obs_t  e;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   t0 = 0;
  int   ht = 0;
  logic [12:0] jh;
  logic [12:0] jv;

  function automatic obs_t mk(
    input logic [7:0] c,
    input bit tv_, fs_, de_, hs_, vs_,
    input int h, v
  );
    obs_t o;
    o.cur = c;
    o.tv  = tv_;
    o.fs  = fs_;
    o.de  = de_;
    o.hs  = hs_;
    o.vs  = vs_;
    o.h   = 13'(h);
    o.v   = 13'(v);
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf(
      "cur=%h tv=%b fs=%b de=%b hs=%b vs=%b h=%0d v=%0d",
      o.cur, o.tv, o.fs, o.de, o.hs, o.vs, o.h, o.v);
  endfunction

  obs_t IDLE_O;

  task automatic snap(input string nm, input int at,
                      input obs_t o);
    exp_t x;
    x.at = at;
    x.nm = nm;
    x.e  = o;
    q.push_back(x);
  endtask

  task automatic px(input string nm, input int h,
                    input int v, input bit de, hs, vs, fs,
                    input logic [7:0] c, input bit val);
    snap(nm, t0 + v * ht + h,
         mk(c, val, fs, de, hs, vs, h, v));
  endtask

  task automatic go(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 30000) begin
      @(negedge clk);
      k++;
    end
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d checks pending, want 0",
               q.size());
      q.delete();
    end
  endtask

  // Skip ahead in the raster by repositioning the counters
  task automatic jump(input int h, input int v);
    @(negedge clk);
    jh = 13'(h);
    jv = 13'(v);
    force dut.u_cnt.r_h = jh;
    force dut.u_cnt.r_v = jv;
    release dut.u_cnt.r_h;
    release dut.u_cnt.r_v;
    t0 = cyc + 1 - (v * ht + h);
  endtask

  // Monitor: compare the due expectation against the outputs
  initial begin
    exp_t x;
    obs_t a;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].at <= cyc) begin
        x = q.pop_front();
        a = mk(cur, tv, vif.o_frame_start, vif.o_de,
               vif.o_hsync, vif.o_vsync,
               int'(vif.o_h_cnt), int'(vif.o_v_cnt));
        n_chk++;
        if (x.at < cyc) begin
          n_fail++;
          $display("FAIL %s: slot %0d missed at %0d",
                   x.nm, x.at, cyc);
        end else if (a !== x.e) begin
          n_fail++;
          $display("FAIL %s: got {%s} want {%s}",
                   x.nm, fmt(a), fmt(x.e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "timeout");
  end

  initial begin
    IDLE_O = mk(8'h00, 0, 0, 0, 0, 0, 0, 0);

    snap("rst_hold", 2, IDLE_O);
    go(3);
    rst_n = 1'b1;
    snap("rst_rel", 5, IDLE_O);
    drain();

    en  = 1'b1;
    res = 8'h33;
    snap("bad_code_a", cyc + 3, IDLE_O);
    snap("bad_code_b", cyc + 10, IDLE_O);
    drain();

    res = RES_1080P60;
    ht  = 2200;
    t0  = cyc + 3;
    snap("load1080", t0 - 1, mk(8'h16, 0, 0, 0, 0, 0, 0, 0));
    px("fs",         0, 0, 1, 0, 0, 1, 8'h16, 1);
    px("fs_drop",    1, 0, 1, 0, 0, 0, 8'h16, 1);
    px("de_last", 1919, 0, 1, 0, 0, 0, 8'h16, 1);
    px("de_off",  1920, 0, 0, 0, 0, 0, 8'h16, 1);
    px("hs_pre",  2007, 0, 0, 0, 0, 0, 8'h16, 1);
    px("hs_on",   2008, 0, 0, 1, 0, 0, 8'h16, 1);
    px("hs_last", 2051, 0, 0, 1, 0, 0, 8'h16, 1);
    px("hs_off",  2052, 0, 0, 0, 0, 0, 8'h16, 1);
    px("line_end",2199, 0, 0, 0, 0, 0, 8'h16, 1);
    px("line1",      0, 1, 1, 0, 0, 0, 8'h16, 1);
    go(t0 + ht + 10);
    res = RES_720P60;
    px("mid_de",  1919, 2, 1, 0, 0, 0, 8'h16, 1);
    px("mid_hs",  2008, 2, 0, 1, 0, 0, 8'h16, 1);
    drain();

    jump(2100, 1079);
    px("vact_end",2150, 1079, 0, 0, 0, 0, 8'h16, 1);
    px("vblank",     0, 1080, 0, 0, 0, 0, 8'h16, 1);
    px("vs_pre",  2199, 1083, 0, 0, 0, 0, 8'h16, 1);
    px("vs_on",      0, 1084, 0, 0, 1, 0, 8'h16, 1);
    px("vs_hs",   2008, 1084, 0, 1, 1, 0, 8'h16, 1);
    px("vs_last", 2199, 1088, 0, 0, 1, 0, 8'h16, 1);
    px("vs_off",     0, 1089, 0, 0, 0, 0, 8'h16, 1);
    drain();

    jump(2100, 1124);
    px("fend1080",2199, 1124, 0, 0, 0, 0, 8'h16, 1);
    snap("load720", t0 + 1125 * 2200,
         mk(8'h04, 0, 0, 0, 0, 0, 0, 0));
    t0 = t0 + 1125 * 2200 + 1;
    ht = 1650;
    px("fs720",      0, 0, 1, 0, 0, 1, 8'h04, 1);
    px("de720_last",1279, 0, 1, 0, 0, 0, 8'h04, 1);
    px("de720_off", 1280, 0, 0, 0, 0, 0, 8'h04, 1);
    px("hs720_pre", 1389, 0, 0, 0, 0, 0, 8'h04, 1);
    px("hs720_on",  1390, 0, 0, 1, 0, 0, 8'h04, 1);
    px("hs720_last",1429, 0, 0, 1, 0, 0, 8'h04, 1);
    px("hs720_off", 1430, 0, 0, 0, 0, 0, 8'h04, 1);
    px("l720_1",     0, 1, 1, 0, 0, 0, 8'h04, 1);
    drain();

    en  = 1'b0;
    res = RES_480P60;
    px("dis_mid",  1390, 3, 0, 1, 0, 0, 8'h04, 1);
    drain();
    jump(1600, 749);
    px("dis_fend", 1649, 749, 0, 0, 0, 0, 8'h00, 1);
    snap("dis_idle",  t0 + 1650 * 750, IDLE_O);
    snap("dis_idle2", t0 + 1650 * 750 + 20, IDLE_O);
    drain();

    en = 1'b1;
    ht = 858;
    t0 = cyc + 3;
    snap("load480", t0 - 1, mk(8'h02, 0, 0, 0, 0, 0, 0, 0));
    px("fs480",      0, 0, 1, 1, 1, 1, 8'h02, 1);
    px("de480_last",719, 0, 1, 1, 1, 0, 8'h02, 1);
    px("de480_off", 720, 0, 0, 1, 1, 0, 8'h02, 1);
    px("hs480_pre", 735, 0, 0, 1, 1, 0, 8'h02, 1);
    px("hs480_on",  736, 0, 0, 0, 1, 0, 8'h02, 1);
    px("hs480_last",797, 0, 0, 0, 1, 0, 8'h02, 1);
    px("hs480_off", 798, 0, 0, 1, 1, 0, 8'h02, 1);
    drain();

    jump(800, 488);
    px("vs480_pre", 857, 488, 0, 1, 1, 0, 8'h02, 1);
    px("vs480_on",    0, 489, 0, 1, 0, 0, 8'h02, 1);
    px("vs480_hs",  736, 490, 0, 0, 0, 0, 8'h02, 1);
    px("vs480_last",857, 494, 0, 1, 0, 0, 8'h02, 1);
    px("vs480_off",   0, 495, 0, 1, 1, 0, 8'h02, 1);
    drain();

    jump(850, 524);
    px("wrap_pre",  857, 524, 0, 1, 1, 0, 8'h02, 1);
    snap("wrap_fs", t0 + 858 * 525,
         mk(8'h02, 1, 1, 1, 1, 1, 0, 0));
    t0 = t0 + 858 * 525;
    px("wrap_next",   1, 0, 1, 1, 1, 0, 8'h02, 1);
    px("pre_rst",   499, 2, 1, 1, 1, 0, 8'h02, 1);
    go(t0 + 2 * ht + 500);
    en    = 1'b0;
    rst_n = 1'b0;
    snap("rst_mid", cyc + 1, IDLE_O);
    go(cyc + 3);
    rst_n = 1'b1;
    snap("rst_after", cyc + 2, IDLE_O);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
